// File: rtl/axis_beat_unpacker.sv
// AXI-Stream width downsizer: buffers one wide beat and emits its kept words
// one per output beat, lowest lane first. A beat with no kept lanes but with
// last set produces a single null-last marker (m_keep=0, m_last=1).
module axis_beat_unpacker #(
  parameter int unsigned WORD_WIDTH     = 16,
  parameter int unsigned BUS_WIDTH      = 64,
  parameter int unsigned WORDS_PER_BEAT = BUS_WIDTH / WORD_WIDTH,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                                      aclk,
  input  logic                                      aresetn,
  output logic                                      s_ready,
  input  logic                                      s_valid,
  input  logic [WORDS_PER_BEAT-1:0][WORD_WIDTH-1:0] s_data,
  input  logic [WORDS_PER_BEAT-1:0]                 s_keep,
  input  logic                                      s_last,
  input  logic                                      m_ready,
  output logic                                      m_valid,
  output logic [WORD_WIDTH-1:0]                     m_data,
  output logic                                      m_keep,
  output logic                                      m_last,
  output logic [CNT_WIDTH-1:0]                      word_count,
  output logic [CNT_WIDTH-1:0]                      pkt_count
);

  localparam int unsigned IdxW = (WORDS_PER_BEAT > 1) ? $clog2(WORDS_PER_BEAT) : 1;

  typedef enum logic [0:0] {StEmpty, StDrain} state_e;

  state_e                                    state_q, state_d;
  logic [WORDS_PER_BEAT-1:0][WORD_WIDTH-1:0] data_q, data_d;
  logic [WORDS_PER_BEAT-1:0]                 rem_q, rem_d;
  logic                                      last_q, last_d;
  logic [CNT_WIDTH-1:0]                      word_cnt_q, word_cnt_d;
  logic [CNT_WIDTH-1:0]                      pkt_cnt_q, pkt_cnt_d;

  logic [IdxW-1:0]           idx;
  logic [WORDS_PER_BEAT-1:0] low_oh;
  logic [WORDS_PER_BEAT-1:0] rem_after;
  logic                      last_word;
  logic                      out_hs;
  logic                      in_hs;

  // Priority encoder: current lane is the lowest remaining kept lane.
  always_comb begin
    idx = '0;
    for (int i = WORDS_PER_BEAT - 1; i >= 0; i--) begin
      if (rem_q[i]) idx = IdxW'(i);
    end
  end

  // Lane bookkeeping and stream outputs, all combinational from the buffer.
  always_comb begin
    low_oh    = rem_q & (~rem_q + WORDS_PER_BEAT'(1));
    rem_after = rem_q & ~low_oh;
    // True when at most one lane is left, i.e. the buffer finishes this word.
    last_word = (rem_after == '0);
    m_valid   = (state_q == StDrain);
    m_keep    = m_valid && (rem_q != '0);
    // Gate with m_keep so the null-last marker carries zero data.
    m_data    = m_keep ? data_q[idx] : '0;
    m_last    = m_valid && last_q && last_word;
    out_hs    = m_valid && m_ready;
    s_ready   = aresetn && ((state_q == StEmpty) || (out_hs && last_word));
    in_hs     = s_valid && s_ready;
  end

  // Next-state: drain one lane per output handshake; a new beat load wins.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    rem_d      = rem_q;
    last_d     = last_q;
    word_cnt_d = word_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;

    if (out_hs) begin
      rem_d = rem_after;
      if (last_word) state_d = StEmpty;
      if (m_keep) word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
      if (m_last) pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
    end

    if (in_hs) begin
      if (s_keep != '0) begin
        data_d  = s_data;
        rem_d   = s_keep;
        last_d  = s_last;
        state_d = StDrain;
      end else if (s_last) begin
        rem_d   = '0;
        last_d  = 1'b1;
        state_d = StDrain;
      end
      // Null beats without last are consumed and dropped.
    end
  end

  // Buffer and counter registers; reset empties the buffer mid-packet.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= StEmpty;
      data_q     <= '0;
      rem_q      <= '0;
      last_q     <= 1'b0;
      word_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      rem_q      <= rem_d;
      last_q     <= last_d;
      word_cnt_q <= word_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign word_count = word_cnt_q;
  assign pkt_count  = pkt_cnt_q;

endmodule

// File: tb/tb_axis_beat_unpacker.sv
// Directed bench for axis_beat_unpacker with 16-bit words on a 64-bit bus.
module tb_axis_beat_unpacker;

  localparam int unsigned WW = 16;
  localparam int unsigned BW = 64;
  localparam int unsigned NW = 4;
  localparam int unsigned CW = 32;

  logic                  aclk = 1'b0;
  logic                  aresetn;
  logic                  s_ready;
  logic                  s_valid;
  logic [NW-1:0][WW-1:0] s_data;
  logic [NW-1:0]         s_keep;
  logic                  s_last;
  logic                  m_ready;
  logic                  m_valid;
  logic [WW-1:0]         m_data;
  logic                  m_keep;
  logic                  m_last;
  logic [CW-1:0]         word_count;
  logic [CW-1:0]         pkt_count;

  int n_checks = 0;
  int n_fail   = 0;

  axis_beat_unpacker #(
    .WORD_WIDTH (WW),
    .BUS_WIDTH  (BW),
    .CNT_WIDTH  (CW)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .s_ready    (s_ready),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_keep     (s_keep),
    .s_last     (s_last),
    .m_ready    (m_ready),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .m_last     (m_last),
    .word_count (word_count),
    .pkt_count  (pkt_count)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_beat(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                            input logic [15:0] d3, input logic [3:0] k, input logic l);
    s_valid = 1'b1;
    s_data  = {d3, d2, d1, d0};
    s_keep  = k;
    s_last  = l;
  endtask

  int            exp_w;
  int            beat;
  int            cyc;
  logic          pend_stall;
  logic [WW-1:0] hold_d;
  logic          hold_l;
  logic          hold_k;
  logic          in_hs;
  logic          out_hs;

  initial begin
    aresetn = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_keep  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;

    // Reset state
    tick();
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_keep", m_keep, 0);
    check("rst_m_last", m_last, 0);
    check("rst_word_count", word_count, 0);
    check("rst_pkt_count", pkt_count, 0);
    tick();
    aresetn = 1'b1;
    #1;
    check("post_rst_s_ready", s_ready, 1);

    // Two full beats, words 0..7 back to back
    m_ready = 1'b1;
    drive_beat(16'd0, 16'd1, 16'd2, 16'd3, 4'b1111, 1'b0);
    #1;
    check("full_idle_valid", m_valid, 0);
    tick();
    for (int k = 0; k < 8; k++) begin
      check("full_valid", m_valid, 1);
      check("full_data", m_data, k);
      check("full_last", m_last, (k == 7));
      check("full_s_ready", s_ready, (k == 3 || k == 7));
      if (k == 0) drive_beat(16'd4, 16'd5, 16'd6, 16'd7, 4'b1111, 1'b1);
      if (k == 4) s_valid = 1'b0;
      tick();
    end
    check("full_done_valid", m_valid, 0);
    check("full_word_count", word_count, 8);
    check("full_pkt_count", pkt_count, 1);

    // Sparse keep 0101: lanes 0 and 2 only
    drive_beat(16'd10, 16'd20, 16'd30, 16'd40, 4'b0101, 1'b1);
    tick();
    s_valid = 1'b0;
    check("sparse_w0", m_data, 10);
    check("sparse_w0_last", m_last, 0);
    tick();
    check("sparse_w1", m_data, 30);
    check("sparse_w1_last", m_last, 1);
    check("sparse_w1_keep", m_keep, 1);
    tick();
    check("sparse_done", m_valid, 0);
    check("sparse_word_count", word_count, 10);

    // Null beat dropped, then single word with last
    drive_beat(16'd99, 16'd99, 16'd99, 16'd99, 4'b0000, 1'b0);
    tick();
    check("null_no_out", m_valid, 0);
    check("null_s_ready", s_ready, 1);
    drive_beat(16'd5, 16'd0, 16'd0, 16'd0, 4'b0001, 1'b1);
    tick();
    s_valid = 1'b0;
    check("null_next_valid", m_valid, 1);
    check("null_next_data", m_data, 5);
    check("null_next_last", m_last, 1);
    check("null_next_keep", m_keep, 1);
    tick();
    check("null_next_done", m_valid, 0);

    // Null-last marker
    drive_beat(16'h1234, 16'h5678, 16'h9abc, 16'hdef0, 4'b0000, 1'b1);
    tick();
    s_valid = 1'b0;
    check("nlast_valid", m_valid, 1);
    check("nlast_keep", m_keep, 0);
    check("nlast_last", m_last, 1);
    check("nlast_data", m_data, 0);
    check("nlast_s_ready", s_ready, 1);
    tick();
    check("nlast_done", m_valid, 0);
    check("nlast_pkt_count", pkt_count, 4);
    check("nlast_word_count", word_count, 11);

    // Random stress: 202 ascending words, sparse source and sink
    exp_w      = 0;
    beat       = 0;
    cyc        = 0;
    pend_stall = 1'b0;
    hold_d     = '0;
    hold_l     = 1'b0;
    hold_k     = 1'b0;
    s_valid    = 1'b0;
    while (exp_w < 202 && cyc < 20000) begin
      if (!s_valid && beat < 51 && $urandom_range(99) < 5) begin
        if (beat == 50) drive_beat(16'd200, 16'd201, 16'hdead, 16'hbeef, 4'b0011, 1'b1);
        else drive_beat(16'(4 * beat), 16'(4 * beat + 1), 16'(4 * beat + 2), 16'(4 * beat + 3),
                        4'b1111, 1'b0);
      end
      m_ready = ($urandom_range(99) < 20);
      #1;
      if (pend_stall) begin
        check("stall_data", m_data, hold_d);
        check("stall_last", m_last, hold_l);
        check("stall_keep", m_keep, hold_k);
      end
      in_hs  = s_valid && s_ready;
      out_hs = m_valid && m_ready;
      if (out_hs) begin
        check("stress_data", m_data, exp_w);
        check("stress_last", m_last, (exp_w == 201));
        check("stress_keep", m_keep, 1);
        exp_w++;
      end
      pend_stall = m_valid && !m_ready;
      hold_d     = m_data;
      hold_l     = m_last;
      hold_k     = m_keep;
      tick();
      cyc++;
      if (in_hs) begin
        s_valid = 1'b0;
        beat++;
      end
    end
    check("stress_words_seen", exp_w, 202);
    s_valid = 1'b0;
    m_ready = 1'b1;
    #1;
    check("stress_done", m_valid, 0);
    check("stress_word_count", word_count, 213);
    check("stress_pkt_count", pkt_count, 5);

    // Reset mid-drain discards buffered words
    drive_beat(16'd100, 16'd101, 16'd102, 16'd103, 4'b1111, 1'b0);
    tick();
    s_valid = 1'b0;
    #1;
    check("rd_w0", m_data, 100);
    tick();
    check("rd_w1", m_data, 101);
    tick();
    check("rd_w2_pending", m_data, 102);
    aresetn = 1'b0;
    #1;
    check("rd_valid", m_valid, 0);
    check("rd_data", m_data, 0);
    check("rd_word_count", word_count, 0);
    check("rd_pkt_count", pkt_count, 0);
    check("rd_s_ready", s_ready, 0);
    repeat (3) tick();
    aresetn = 1'b1;
    #1;
    check("rd_rel_s_ready", s_ready, 1);
    check("rd_rel_valid", m_valid, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rd_no_stale", m_valid, 0);
    end
    drive_beat(16'd7, 16'd0, 16'd0, 16'd0, 4'b0001, 1'b1);
    tick();
    s_valid = 1'b0;
    check("rd_recover_data", m_data, 7);
    check("rd_recover_last", m_last, 1);
    tick();
    check("rd_recover_done", m_valid, 0);
    check("rd_recover_words", word_count, 1);
    check("rd_recover_pkts", pkt_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_beat_unpacker.md
Name: axis_beat_unpacker

Overview:
- Synthesizable AXI-Stream width downsizer. Accepts wide multi-word beats with per-word keep and last.
- Emits one kept word per output beat, in lane order: lane 0 first.
- Sits between the wide-bus stream producers and word-serial consumers in the datapath.
- Carries running word and packet counters for debug and bench cross-checking.

Parameters:
- WORD_WIDTH, 16, bits per word.
- BUS_WIDTH, 64, input bus width in bits. Must be an integer multiple of WORD_WIDTH.
- WORDS_PER_BEAT, BUS_WIDTH/WORD_WIDTH, derived lanes per input beat. Do not override.
- CNT_WIDTH, 32, width of the status counters.

Ports:
- aclk  input  1  clock; all logic on rising edge.
- aresetn  input  1  asynchronous active-low reset.
- s_ready  output  1  input stream ready.
- s_valid  input  1  input stream valid.
- s_data  input  WORDS_PER_BEAT x WORD_WIDTH  input beat, lane i = s_data[i].
- s_keep  input  WORDS_PER_BEAT  per-lane keep.
- s_last  input  1  final beat of packet.
- m_ready  input  1  output stream ready.
- m_valid  output  1  output stream valid.
- m_data  output  WORD_WIDTH  output word.
- m_keep  output  1  1 = real word; 0 only for the null-last marker.
- m_last  output  1  final word of packet.
- word_count  output  CNT_WIDTH  output handshakes with m_keep=1, wraps at 2^CNT_WIDTH.
- pkt_count  output  CNT_WIDTH  output handshakes with m_last=1, wraps.

Behaviour:
- Reset is asynchronous on aresetn low and releases on the clock.
  - Beat buffer is emptied.
  - word_count and pkt_count go to 0.
  - m_valid, m_data, m_keep and m_last go to 0.
  - s_ready is forced to 0 while aresetn=0.
- One-beat buffer:
  - Holds data regs, a remaining-lanes mask (rem) and a last flag.
  - State EMPTY when no buffered beat, DRAIN otherwise.
- Current lane: idx = lowest set bit of rem, found by a priority encoder.
- Outputs are combinational from the buffer registers:
  - m_valid = DRAIN.
  - m_data = data[idx].
  - m_keep = (rem != 0).
  - m_last = last_flag && (rem has at most one bit set).
  - m_data, m_keep and m_last are driven 0 whenever m_valid=0.
- s_ready = aresetn && (EMPTY || (m_valid && m_ready && m_last_word)).
  - m_last_word = rem has at most one bit set, i.e. the buffered beat finishes this cycle.
  - Result: back-to-back beats with zero bubble. Sustained throughput is one word per cycle.
- Input handshake (s_valid && s_ready), loading the beat:
  - If s_keep != 0: load data, rem=s_keep, last_flag=s_last; next state DRAIN.
  - If s_keep == 0 and s_last=1 (null-last beat): load rem=0, last_flag=1; next state DRAIN. Emits exactly one beat with m_keep=0, m_last=1, m_data=0.
  - If s_keep == 0 and s_last=0 (null beat): drop it. State unchanged, no output.
- Output handshake (m_valid && m_ready):
  - Clear bit idx of rem.
  - If that emptied rem (or rem was already 0), go to EMPTY, unless a new beat loads the same cycle, which takes priority.
- Latency: an input handshake at edge N gives m_valid high after edge N. First word is available in the cycle after acceptance.
- Hold rules:
  - While m_valid=1 and m_ready=0, m_data, m_keep and m_last hold stable.
  - s_data is never sampled unless s_valid && s_ready.
- Counters:
  - word_count increments on each output handshake with m_keep=1.
  - pkt_count increments on each output handshake with m_last=1, including the null-last marker.
  - Both wrap silently.
- Non-contiguous keep (e.g. 1010) is legal. Cleared lanes are skipped with no idle cycle.
- Reset mid-packet discards all buffered words. No partial-packet output occurs after release.

Test Plan:
- Full beats, 4 lanes: beat0 data 0,1,2,3 keep 1111; beat1 data 4..7 keep 1111 last=1; m_ready=1, s_valid=1 -> words 0..7 on 8 consecutive cycles.
  - m_last only with word 7.
  - s_ready high only on the cycles that emit words 3 and 7.
  - Final counts word_count=8, pkt_count=1.
- Sparse keep: lanes {0:10,1:20,2:30,3:40}, keep 0101, last=1 -> outputs 10 then 30 on consecutive cycles, m_last with 30, word_count=2.
- Null beats: keep 0000 last=0, then lane0=5 keep 0001 last=1 -> null beat accepted in one cycle, no output; single output 5 with m_last=1, m_keep=1.
- Null-last beat: keep 0000, last=1 -> one output beat m_keep=0, m_last=1, m_data=0; pkt_count +1, word_count unchanged.
- Random stress, reusing the bench source/sink models: s_valid probability 5%, m_ready probability 20%, 202 ascending words packed 4 per beat with final beat keep 0011 and last=1 -> output sequence is 0..201 exactly, m_last only on 201, word_count=202, m_data stable while stalled.
- Reset mid-drain: beat 0..3 keep 1111; after 2 words handshaken, pull aresetn low for 3 cycles -> m_valid=0 and counters 0 immediately. After release, s_ready=1 and no stale words 2 or 3 appear.
